// File: rtl/alu_cmd_issuer.sv
// Purpose : sequencer that registers one command onto a combinational ALU,
//           waits SETTLE_CYCLES, then captures and returns res/zero/overflow.
// Latency : command accepted at edge E0 -> rsp_valid high after edge E0+SETTLE_CYCLES.
// Backpressure: one command in flight. cmd_ready stays low from accept until the
//           response handshake. rsp_* are held while rsp_ready is low.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op/cmd_a/cmd_b command payload
//   alu_operation/alu_a/alu_b  registered drive into the ALU
//   alu_res/alu_zero/alu_overflow  combinational results from the ALU
//   rsp_valid/rsp_ready        response handshake; rsp_res/rsp_zero/rsp_overflow payload
//   busy                       high whenever the FSM is not in IDLE
//   stat_ops/stat_ovf          saturating handshake counters (only with ALU_ISSUER_STATS_EN)
//
// Optional feature macro: ALU_ISSUER_STATS_EN
module alu_cmd_issuer #(
  parameter int unsigned SETTLE_CYCLES = 1,  // legal range 1..15
  parameter int unsigned WIDTH         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [2:0]       alu_operation,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_zero,
  output logic             rsp_overflow,
`ifdef ALU_ISSUER_STATS_EN
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_ovf,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  // The counter is loaded with SETTLE_CYCLES-1 so that the capture edge lands
  // exactly SETTLE_CYCLES edges after the accept edge.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      busy          <= 1'b0;
      alu_operation <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      rsp_res       <= '0;
      rsp_zero      <= 1'b0;
      rsp_overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_operation <= cmd_op;
            alu_a         <= cmd_a;
            alu_b         <= cmd_b;
            cnt           <= CNT_LOAD;
            cmd_ready     <= 1'b0;
            busy          <= 1'b1;
            state         <= SETTLE;
          end
        end
        SETTLE: begin
          // alu_* are untouched here, so the ALU inputs stay stable until
          // the next accepted command.
          if (cnt == 4'd0) begin
            rsp_res      <= alu_res;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // rsp_* keep the captured value after the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ISSUER_STATS_EN
  logic rsp_fire;
  assign rsp_fire = (state == RESP) && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_ovf <= '0;
    end else if (rsp_fire) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (rsp_overflow && (stat_ovf != 16'hFFFF)) stat_ovf <= stat_ovf + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer. Instance 0 uses SETTLE_CYCLES=1 and instance 1
// uses SETTLE_CYCLES=3. Each instance drives its own behavioural ALU (op 2=add, op 6=sub).
module tb_alu_cmd_issuer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [2:0]  cmd_op    [2];
  logic [31:0] cmd_a     [2];
  logic [31:0] cmd_b     [2];
  logic [2:0]  alu_op    [2];
  logic [31:0] alu_a     [2];
  logic [31:0] alu_b     [2];
  logic [31:0] alu_res   [2];
  logic        alu_zero  [2];
  logic        alu_ovf   [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_res   [2];
  logic        rsp_zero  [2];
  logic        rsp_ovf   [2];
  logic        busy      [2];
`ifdef ALU_ISSUER_STATS_EN
  logic [15:0] stat_ops  [2];
  logic [15:0] stat_ovf  [2];
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } rsp_t;

  rsp_t sb[$];

  function automatic logic [33:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (op)
      3'd2: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd6: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      default: ;
    endcase
    return {v, (r == 32'd0), r};
  endfunction

  assign {alu_ovf[0], alu_zero[0], alu_res[0]} = alu_f(alu_op[0], alu_a[0], alu_b[0]);
  assign {alu_ovf[1], alu_zero[1], alu_res[1]} = alu_f(alu_op[1], alu_a[1], alu_b[1]);

  alu_cmd_issuer #(.SETTLE_CYCLES(1), .WIDTH(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
    .alu_operation(alu_op[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
    .alu_res(alu_res[0]), .alu_zero(alu_zero[0]), .alu_overflow(alu_ovf[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_res(rsp_res[0]), .rsp_zero(rsp_zero[0]), .rsp_overflow(rsp_ovf[0]),
`ifdef ALU_ISSUER_STATS_EN
    .stat_ops(stat_ops[0]), .stat_ovf(stat_ovf[0]),
`endif
    .busy(busy[0])
  );

  alu_cmd_issuer #(.SETTLE_CYCLES(3), .WIDTH(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
    .alu_operation(alu_op[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
    .alu_res(alu_res[1]), .alu_zero(alu_zero[1]), .alu_overflow(alu_ovf[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_res(rsp_res[1]), .rsp_zero(rsp_zero[1]), .rsp_overflow(rsp_ovf[1]),
`ifdef ALU_ISSUER_STATS_EN
    .stat_ops(stat_ops[1]), .stat_ovf(stat_ovf[1]),
`endif
    .busy(busy[1])
  );

  // Drives a command at a negedge, holds it until accepted, then returns at the
  // negedge right after the accept edge.
  task automatic issue(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit ok;
    ok = 1'b0;
    cmd_valid[d] = 1'b1; cmd_op[d] = op; cmd_a[d] = a; cmd_b[d] = b;
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready[d] === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL issue_timeout dut%0d: cmd_ready never seen", d); end
    @(negedge clk);
    cmd_valid[d] = 1'b0;
    checks++;
    if (alu_op[d] !== op || alu_a[d] !== a || alu_b[d] !== b) begin
      errors++;
      $display("FAIL alu_drive dut%0d: got op=%0d a=%h b=%h, want op=%0d a=%h b=%h",
               d, alu_op[d], alu_a[d], alu_b[d], op, a, b);
    end
    checks++;
    if (busy[d] !== 1'b1 || cmd_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0) begin
      errors++;
      $display("FAIL settle_flags dut%0d: busy=%b cmd_ready=%b rsp_valid=%b, want 1 0 0",
               d, busy[d], cmd_ready[d], rsp_valid[d]);
    end
  endtask

  // Waits for rsp_valid, checks the latency and the payload against the
  // scoreboard, then completes the handshake and checks the return to IDLE.
  task automatic collect(input int d, input int lat);
    int   n;
    rsp_t exp;
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n != lat) begin errors++; $display("FAIL latency dut%0d: got %0d, want %0d", d, n, lat); end
    exp = '0;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty dut%0d: got response, want none", d);
    end else begin
      exp = sb.pop_front();
      if (rsp_res[d] !== exp.res || rsp_zero[d] !== exp.zero || rsp_ovf[d] !== exp.ovf) begin
        errors++;
        $display("FAIL rsp_data dut%0d: got res=%h z=%b v=%b, want res=%h z=%b v=%b",
                 d, rsp_res[d], rsp_zero[d], rsp_ovf[d], exp.res, exp.zero, exp.ovf);
      end
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid[d] !== 1'b0 || cmd_ready[d] !== 1'b1 || busy[d] !== 1'b0 || rsp_res[d] !== exp.res) begin
      errors++;
      $display("FAIL handshake dut%0d: rsp_valid=%b cmd_ready=%b busy=%b res=%h, want 0 1 0 %h",
               d, rsp_valid[d], cmd_ready[d], busy[d], rsp_res[d], exp.res);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (cmd_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
          alu_op[d] !== 3'd0 || alu_a[d] !== 32'd0 || alu_b[d] !== 32'd0 ||
          rsp_res[d] !== 32'd0 || rsp_zero[d] !== 1'b0 || rsp_ovf[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s dut%0d: rdy=%b vld=%b busy=%b op=%0d a=%h b=%h res=%h z=%b v=%b, want 1 0 0 and zeros",
                 tag, d, cmd_ready[d], rsp_valid[d], busy[d], alu_op[d], alu_a[d], alu_b[d],
                 rsp_res[d], rsp_zero[d], rsp_ovf[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0; cmd_op[d] = '0; cmd_a[d] = '0; cmd_b[d] = '0; rsp_ready[d] = 1'b0;
    end
    #7 rst_n = 1'b0;   // between clock edges: only the asynchronous path can act
    #1 check_reset_vals("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_release");
  endtask

  task automatic test_basic_add();
    rsp_ready[0] = 1'b1;
    sb.push_back('{res: 32'd10, zero: 1'b0, ovf: 1'b0});
    issue(0, 3'd2, 32'd6, 32'd4);
    collect(0, 1);
  endtask

  task automatic test_zero_overflow();
    sb.push_back('{res: 32'd0, zero: 1'b1, ovf: 1'b0});
    issue(0, 3'd6, 32'd576, 32'd576);
    collect(0, 1);
    sb.push_back('{res: 32'h8000_0000, zero: 1'b0, ovf: 1'b1});
    issue(0, 3'd2, 32'h7FFF_FFFF, 32'd1);
    collect(0, 1);
  endtask

`ifdef ALU_ISSUER_STATS_EN
  task automatic test_stats();
    checks++;
    if (stat_ops[0] !== 16'd3 || stat_ovf[0] !== 16'd1) begin
      errors++;
      $display("FAIL stats: got ops=%0d ovf=%0d, want 3 1", stat_ops[0], stat_ovf[0]);
    end
  endtask
`endif

  task automatic test_backpressure();
    int   n;
    rsp_t exp;
    bit   bad;
    rsp_ready[1] = 1'b0;
    sb.push_back('{res: 32'd123, zero: 1'b0, ovf: 1'b0});
    issue(1, 3'd2, 32'd100, 32'd23);
    n = 0;
    while (rsp_valid[1] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n != 3) begin errors++; $display("FAIL bp_latency: got %0d, want 3", n); end
    exp = sb.pop_front();
    // Second command is presented while the first response is stalled.
    cmd_valid[1] = 1'b1; cmd_op[1] = 3'd6; cmd_a[1] = 32'd50; cmd_b[1] = 32'd50;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b1 || rsp_res[1] !== exp.res || rsp_zero[1] !== exp.zero ||
          rsp_ovf[1] !== exp.ovf || cmd_ready[1] !== 1'b0 || alu_a[1] !== 32'd100) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: vld=%b res=%h rdy=%b alu_a=%h, want 1 %h 0 00000064",
               rsp_valid[1], rsp_res[1], cmd_ready[1], alu_a[1], exp.res);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid[1] !== 1'b0 || cmd_ready[1] !== 1'b1 || alu_a[1] !== 32'd100) begin
      errors++;
      $display("FAIL bp_release: vld=%b rdy=%b alu_a=%h, want 0 1 00000064",
               rsp_valid[1], cmd_ready[1], alu_a[1]);
    end
    @(negedge clk);
    cmd_valid[1] = 1'b0;
    checks++;
    if (alu_a[1] !== 32'd50 || alu_op[1] !== 3'd6 || busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_held_accept: alu_a=%h op=%0d busy=%b, want 00000032 6 1",
               alu_a[1], alu_op[1], busy[1]);
    end
    sb.push_back('{res: 32'd0, zero: 1'b1, ovf: 1'b0});
    collect(1, 3);
  endtask

  task automatic test_reset_mid_op();
    bit seen;
    rsp_ready[1] = 1'b1;
    issue(1, 3'd2, 32'd5, 32'd5);   // discarded by reset, so nothing is expected
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset_mid_settle");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_discard: got rsp_valid=1, want 0"); end
    sb.push_back('{res: 32'd1, zero: 1'b0, ovf: 1'b0});
    issue(1, 3'd2, 32'hFFFF_FFFF, 32'd2);
    collect(1, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_add();
    test_zero_overflow();
`ifdef ALU_ISSUER_STATS_EN
    test_stats();
`endif
    test_backpressure();
    test_reset_mid_op();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
